// File: rtl/bus_rr_mux.sv
// Multi-master / multi-slave system bus: registered round-robin arbiter with optional
// grant-length limit, base/mask slave decode and a one-cycle registered read return path.
module bus_rr_mux #(
  parameter int unsigned         NUM_M     = 2,
  parameter int unsigned         NUM_S     = 2,
  parameter int unsigned         AW        = 16,
  parameter int unsigned         DW        = 64,
  parameter logic [NUM_S*AW-1:0] SLV_BASE  = {16'h7000, 16'h0000},
  parameter logic [NUM_S*AW-1:0] SLV_MASK  = {16'hFE00, 16'hF800},
  parameter int unsigned         GRANT_MAX = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_M-1:0]    m_req,
  input  logic [NUM_M-1:0]    m_wr,
  input  logic [NUM_M*AW-1:0] m_addr,
  input  logic [NUM_M*DW-1:0] m_dout,
  output logic [NUM_M-1:0]    m_grant,
  output logic [DW-1:0]       m_din,
  output logic                bus_err,
  output logic [NUM_S-1:0]    s_sel,
  output logic                s_wr,
  output logic [AW-1:0]       s_addr,
  output logic [DW-1:0]       s_din,
  input  logic [NUM_S*DW-1:0] s_dout
);

  localparam int unsigned IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int unsigned SW = (NUM_S > 1) ? $clog2(NUM_S) : 1;
  localparam int unsigned CW = (GRANT_MAX > 0) ? $clog2(GRANT_MAX + 1) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IW-1:0]    last_q, last_d;
  logic [NUM_M-1:0] grant_q, grant_d;
  logic             rd_vld_q, rd_vld_d;
  logic [SW-1:0]    rd_idx_q, rd_idx_d;
  logic             err_q, err_d;

  logic [IW-1:0]    win_c;
  logic             any_c;
  logic             others_c;
  logic             act_c;
  logic             limit_c;
  logic             hit_c;
  logic [SW-1:0]    hit_idx_c;

  // First requester searching upward from last+1; iterating backwards leaves the nearest one.
  always_comb begin : next_owner
    logic [IW-1:0] cand;
    cand  = '0;
    win_c = last_q;
    for (int k = int'(NUM_M); k >= 1; k--) begin
      cand = IW'((32'(last_q) + 32'(k)) % NUM_M);
      if (m_req[cand]) win_c = cand;
    end
  end

  assign any_c    = |m_req;
  assign others_c = |(m_req & ~grant_q);
  assign act_c    = |(m_req & grant_q);

  // Grant-length counter; only exists when a limit is configured.
  if (GRANT_MAX > 0) begin : g_cnt
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (grant_d != grant_q) begin
        cnt_d = '0;
      end else if (|grant_q && (cnt_q < CW'(GRANT_MAX))) begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
    end

    assign limit_c = (cnt_q >= CW'(GRANT_MAX - 1));
  end else begin : g_no_cnt
    assign limit_c = 1'b0;
  end

  // Arbiter FSM: ownership moves on release or on hitting the grant limit while others wait.
  always_comb begin : arb_fsm
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (any_c) begin
          state_d        = ST_OWN;
          last_d         = win_c;
          grant_d        = '0;
          grant_d[win_c] = 1'b1;
        end
      end
      ST_OWN: begin
        if ((!act_c && others_c) || (act_c && others_c && limit_c)) begin
          last_d         = win_c;
          grant_d        = '0;
          grant_d[win_c] = 1'b1;
        end else if (!act_c) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin : bus_drive
    s_addr = '0;
    s_wr   = 1'b0;
    s_din  = '0;
    if (act_c) begin
      s_addr = m_addr[32'(last_q)*AW +: AW];
      s_wr   = m_wr[last_q];
      s_din  = m_dout[32'(last_q)*DW +: DW];
    end
  end

  // Lowest matching slave wins on overlapping windows.
  always_comb begin : decode
    hit_c     = 1'b0;
    hit_idx_c = '0;
    for (int i = int'(NUM_S) - 1; i >= 0; i--) begin
      if ((s_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        hit_c     = 1'b1;
        hit_idx_c = SW'(i);
      end
    end
    s_sel = '0;
    if (act_c && hit_c) s_sel[hit_idx_c] = 1'b1;
  end

  always_comb begin : ret_next
    rd_vld_d = act_c & hit_c & ~s_wr;
    rd_idx_d = hit_idx_c;
    err_d    = act_c & ~hit_c;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      last_q   <= IW'(NUM_M - 1);
      grant_q  <= '0;
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      rd_vld_q <= rd_vld_d;
      rd_idx_q <= rd_idx_d;
      err_q    <= err_d;
    end
  end

  // Slaves present read data the cycle after the access, so the registered index steers it.
  always_comb begin : read_return
    m_din = '0;
    if (rd_vld_q) m_din = s_dout[32'(rd_idx_q)*DW +: DW];
  end

  assign m_grant = grant_q;
  assign bus_err = err_q;

endmodule

// File: tb/tb_bus_rr_mux.sv
// Bench for bus_rr_mux: two masters, synchronous RAM slaves at 0x0000/0x7000,
// directed scenarios plus randomized traffic against a behavioural bus model.
module tb_bus_rr_mux;

  localparam int NM = 2;
  localparam int NS = 2;
  localparam int AW = 16;
  localparam int DW = 64;
  localparam int GM = 4;
  localparam logic [63:0] PAT = 64'hDEAD_BEEF_0123_4567;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NM-1:0]     m_req, m_wr, m_grant;
  logic [NM*AW-1:0]  m_addr;
  logic [NM*DW-1:0]  m_dout;
  logic [DW-1:0]     m_din;
  logic              bus_err;
  logic [NS-1:0]     s_sel;
  logic              s_wr;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_din;
  logic [NS*DW-1:0]  s_dout;
  logic              ram_clr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_rr_mux #(
    .NUM_M(NM), .NUM_S(NS), .AW(AW), .DW(DW),
    .SLV_BASE({16'h7000, 16'h0000}), .SLV_MASK({16'hFE00, 16'hF800}),
    .GRANT_MAX(GM)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout),
    .m_grant(m_grant), .m_din(m_din), .bus_err(bus_err),
    .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout)
  );

  // Synchronous-read RAM slaves, 32 words each
  logic [DW-1:0] ram0 [32];
  logic [DW-1:0] ram1 [32];
  logic [DW-1:0] dout0, dout1;
  assign s_dout = {dout1, dout0};

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 32; i++) begin
        ram0[i] <= '0;
        ram1[i] <= '0;
      end
    end else begin
      if (s_sel[0] && s_wr)  ram0[s_addr[4:0]] <= s_din;
      if (s_sel[0] && !s_wr) dout0 <= ram0[s_addr[4:0]];
      if (s_sel[1] && s_wr)  ram1[s_addr[4:0]] <= s_din;
      if (s_sel[1] && !s_wr) dout1 <= ram1[s_addr[4:0]];
    end
  end

  // Behavioural model: owner index (-1 = idle), rotation pointer, tenure count, memories
  int          mo_owner, mo_last, mo_cnt;
  bit          mo_rd, mo_err;
  logic [63:0] mo_rd_data;
  logic [63:0] ref0 [32];
  logic [63:0] ref1 [32];
  int          base [NS] = '{32'h0000, 32'h7000};
  int          mask [NS] = '{32'hF800, 32'hFE00};

  bit          e_act, e_hit, e_wr;
  int          e_idx;
  logic [15:0] e_addr;
  logic [63:0] e_sdin;
  logic [1:0]  e_sel;

  function automatic void model_reset();
    mo_owner = -1;
    mo_last  = NM - 1;
    mo_cnt   = 0;
    mo_rd    = 1'b0;
    mo_err   = 1'b0;
    mo_rd_data = '0;
  endfunction

  function automatic logic [1:0] e_grant();
    return (mo_owner < 0) ? 2'b00 : 2'(1 << mo_owner);
  endfunction

  function automatic logic [63:0] e_din();
    return mo_rd ? mo_rd_data : 64'd0;
  endfunction

  function automatic void model_comb();
    e_act  = (mo_owner >= 0) && (m_req[mo_owner] == 1'b1);
    e_addr = '0;
    e_wr   = 1'b0;
    e_sdin = '0;
    if (e_act) begin
      e_addr = m_addr[mo_owner*AW +: AW];
      e_wr   = m_wr[mo_owner];
      e_sdin = m_dout[mo_owner*DW +: DW];
    end
    e_hit = 1'b0;
    e_idx = 0;
    for (int i = 0; i < NS; i++) begin
      if (!e_hit && ((int'(e_addr) & mask[i]) == base[i])) begin
        e_hit = 1'b1;
        e_idx = i;
      end
    end
    e_sel = (e_act && e_hit) ? 2'(1 << e_idx) : 2'b00;
  endfunction

  function automatic void model_clock();
    int win;
    int c;
    bit others;
    model_comb();
    mo_rd  = e_act && e_hit && !e_wr;
    mo_err = e_act && !e_hit;
    if (mo_rd) mo_rd_data = (e_idx == 0) ? ref0[e_addr[4:0]] : ref1[e_addr[4:0]];
    if (e_act && e_hit && e_wr) begin
      if (e_idx == 0) ref0[e_addr[4:0]] = e_sdin;
      else            ref1[e_addr[4:0]] = e_sdin;
    end
    win = -1;
    for (int k = 1; k <= NM; k++) begin
      c = (mo_last + k) % NM;
      if (win < 0 && m_req[c]) win = c;
    end
    others = 1'b0;
    for (int j = 0; j < NM; j++) if (j != mo_owner && m_req[j]) others = 1'b1;
    if (mo_owner < 0 || !m_req[mo_owner]) begin
      mo_owner = win;
      if (win >= 0) begin
        mo_last = win;
        mo_cnt  = 0;
      end
    end else if (others && GM > 0 && mo_cnt >= GM - 1) begin
      mo_owner = win;
      mo_last  = win;
      mo_cnt   = 0;
    end else if (mo_cnt < GM) begin
      mo_cnt++;
    end
  endfunction

  task automatic drive(input int j, input bit rq, input bit w, input logic [15:0] a,
                       input logic [63:0] d);
    m_req[j] = rq;
    m_wr[j]  = w;
    m_addr[j*AW +: AW] = a;
    m_dout[j*DW +: DW] = d;
  endtask

  task automatic idle_all();
    m_req = '0; m_wr = '0; m_addr = '0; m_dout = '0;
  endtask

  task automatic settle();
    #1;
    model_comb();
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ram_clr = 1'b1;
    idle_all();
    model_reset();
    for (int i = 0; i < 32; i++) begin
      ref0[i] = '0;
      ref1[i] = '0;
    end
    @(negedge clk);
    ram_clr = 1'b0;
    reset_n = 1'b1;
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 3))
      0, 1:    return 16'h0000 + 16'($urandom_range(0, 31));
      2:       return 16'h7000 + 16'($urandom_range(0, 31));
      default: return 16'h3000 + 16'($urandom_range(0, 4095));
    endcase
  endfunction

  task automatic test_reset();
    idle_all();
    reset_n = 1'b0;
    ram_clr = 1'b1;
    #1;
    checks++;
    if ({m_grant, bus_err, m_din} !== '0) begin
      failures++;
      $display("FAIL reset_regs: grant=%b err=%b din=%h, want all zero", m_grant, bus_err, m_din);
    end
    drive(0, 1, 1, 16'h0010, PAT);
    drive(1, 1, 0, 16'h7000, 64'd1);
    #1;
    checks++;
    if ({s_sel, s_wr, s_addr, s_din} !== '0) begin
      failures++;
      $display("FAIL reset_bus: sel=%b wr=%b addr=%h din=%h, want all zero", s_sel, s_wr, s_addr, s_din);
    end
    @(posedge clk);
    #1;
    checks++;
    if (m_grant !== 2'b00) begin
      failures++;
      $display("FAIL reset_hold_grant: got %b want 00", m_grant);
    end
    do_reset();
  endtask

  task automatic test_single_master();
    drive(0, 1, 1, 16'h0010, PAT);
    settle();
    checks++;
    if (m_grant !== 2'b00) begin
      failures++;
      $display("FAIL sm_grant_latency: got %b want 00", m_grant);
    end
    tick();
    checks++;
    if (m_grant !== 2'b01) begin
      failures++;
      $display("FAIL sm_grant: got %b want 01", m_grant);
    end
    settle();
    checks++;
    if ({s_sel, s_wr, s_addr, s_din} !== {2'b01, 1'b1, 16'h0010, PAT}) begin
      failures++;
      $display("FAIL sm_write_bus: sel=%b wr=%b addr=%h din=%h want 01/1/0010/%h", s_sel, s_wr, s_addr, s_din, PAT);
    end
    tick();
    drive(0, 1, 0, 16'h0010, 64'd0);
    settle();
    checks++;
    if ({s_sel, s_wr, m_din} !== {2'b01, 1'b0, 64'd0}) begin
      failures++;
      $display("FAIL sm_read_bus: sel=%b wr=%b din=%h want 01/0/0", s_sel, s_wr, m_din);
    end
    tick();
    checks++;
    if (m_din !== PAT || m_din !== e_din()) begin
      failures++;
      $display("FAIL sm_read_data: got %h want %h", m_din, PAT);
    end
    drive(0, 0, 0, 16'h0000, 64'd0);
    tick();
    checks++;
    if ({m_grant, m_din} !== {2'b00, 64'd0}) begin
      failures++;
      $display("FAIL sm_release: grant=%b din=%h want 00/0", m_grant, m_din);
    end
  endtask

  task automatic test_decode();
    drive(0, 1, 1, 16'h7008, 64'h0123_4567_89AB_CDEF);
    tick();
    settle();
    checks++;
    if (s_sel !== 2'b10) begin
      failures++;
      $display("FAIL dec_slave1: sel=%b want 10", s_sel);
    end
    tick();
    drive(0, 1, 0, 16'h3000, 64'd0);
    settle();
    checks++;
    if ({s_sel, s_addr} !== {2'b00, 16'h3000}) begin
      failures++;
      $display("FAIL dec_unmapped_sel: sel=%b addr=%h want 00/3000", s_sel, s_addr);
    end
    tick();
    checks++;
    if ({bus_err, m_din} !== {1'b1, 64'd0}) begin
      failures++;
      $display("FAIL dec_bus_err: err=%b din=%h want 1/0", bus_err, m_din);
    end
    drive(0, 1, 0, 16'h7008, 64'd0);
    tick();
    checks++;
    if ({bus_err, m_din} !== {1'b0, 64'h0123_4567_89AB_CDEF}) begin
      failures++;
      $display("FAIL dec_err_pulse_read1: err=%b din=%h want 0/0123456789abcdef", bus_err, m_din);
    end
    drive(0, 0, 0, 16'h0000, 64'd0);
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] want;
    do_reset();
    drive(0, 1, 0, 16'h0010, 64'd0);
    drive(1, 1, 0, 16'h7008, 64'd0);
    for (int c = 1; c <= 12; c++) begin
      settle();
      tick();
      want = (((c - 1) / GM) % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (m_grant !== want || m_grant !== e_grant()) begin
        failures++;
        $display("FAIL rr_rotation cycle %0d: got %b want %b", c, m_grant, want);
      end
    end
    idle_all();
    tick();
  endtask

  task automatic test_release();
    do_reset();
    drive(0, 1, 1, 16'h0020, 64'h11);
    tick();
    drive(1, 1, 1, 16'h7010, 64'h22);
    tick();
    checks++;
    if (m_grant !== 2'b01) begin
      failures++;
      $display("FAIL rel_hold: got %b want 01", m_grant);
    end
    drive(0, 0, 0, 16'h0000, 64'd0);
    tick();
    checks++;
    if (m_grant !== 2'b10) begin
      failures++;
      $display("FAIL rel_handover: got %b want 10", m_grant);
    end
    drive(1, 0, 0, 16'h0000, 64'd0);
    tick();
    checks++;
    if (m_grant !== 2'b00) begin
      failures++;
      $display("FAIL rel_idle: got %b want 00", m_grant);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive(0, 1, 0, 16'h0004, 64'd0);
    drive(1, 1, 0, 16'h7004, 64'd0);
    tick();
    checks++;
    if (m_grant !== 2'b01) begin
      failures++;
      $display("FAIL sim_first: got %b want 01", m_grant);
    end
    drive(0, 0, 0, 16'h0000, 64'd0);
    tick();
    checks++;
    if (m_grant !== 2'b10) begin
      failures++;
      $display("FAIL sim_second: got %b want 10", m_grant);
    end
    idle_all();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 300; n++) begin
      for (int j = 0; j < NM; j++)
        drive(j, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rand_addr(),
              {$urandom, $urandom});
      settle();
      checks++;
      if ({s_sel, s_wr, s_addr, s_din} !== {e_sel, e_wr, e_addr, e_sdin}) begin
        failures++;
        $display("FAIL rnd_bus n=%0d: sel=%b wr=%b addr=%h din=%h want %b/%b/%h/%h",
                 n, s_sel, s_wr, s_addr, s_din, e_sel, e_wr, e_addr, e_sdin);
      end
      tick();
      checks++;
      if ({m_grant, bus_err, m_din} !== {e_grant(), mo_err, e_din()}) begin
        failures++;
        $display("FAIL rnd_ret n=%0d: grant=%b err=%b din=%h want %b/%b/%h",
                 n, m_grant, bus_err, m_din, e_grant(), mo_err, e_din());
      end
    end
    idle_all();
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(0, 1, 1, 16'h0018, PAT);
    tick();
    tick();
    drive(0, 1, 0, 16'h0018, 64'd0);
    tick();
    checks++;
    if (m_din !== PAT) begin
      failures++;
      $display("FAIL ar_pre_read: got %h want %h", m_din, PAT);
    end
    settle();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({m_grant, bus_err, m_din, s_sel} !== '0) begin
      failures++;
      $display("FAIL ar_clear: grant=%b err=%b din=%h sel=%b want all zero", m_grant, bus_err, m_din, s_sel);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 1, 0, 16'h0018, 64'd0);
    drive(1, 1, 0, 16'h7000, 64'd0);
    settle();
    tick();
    checks++;
    if ({m_grant, bus_err, m_din} !== {2'b01, 1'b0, 64'd0}) begin
      failures++;
      $display("FAIL ar_restart: grant=%b err=%b din=%h want 01/0/0", m_grant, bus_err, m_din);
    end
    idle_all();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_master();
    test_decode();
    test_round_robin();
    test_release();
    test_simultaneous();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
